// File: rtl/instruction_sequencer.sv
// -----------------------------------------------------------------------------
// instruction_sequencer
//
// Purpose:
//   Sequences one instruction at a time through the stages FETCH, DECODE,
//   EXECUTE, an optional MEMORY stage and WRITEBACK. The inputs come from a
//   separate control_unit. The block stops cleanly at an instruction boundary
//   when a halt is requested. It enters a sticky FAULT state when a RAM access
//   waits for mem_ready for too long. Two free-running counters track retired
//   instructions and active (busy) cycles.
//
// Parameters:
//   WAIT_LIMIT          number of MEMORY cycles the block waits for mem_ready
//                       before it gives up and enters FAULT (1..255)
//
// Ports:
//   clock               system clock; every state update is on its rising edge
//   reset               asynchronous, active-high reset
//   run                 start/resume request; only looked at in IDLE and HALTED
//   halt_req            single-cycle halt request, taken at the next boundary
//   ctrl_ramconfig      RAM write enable from the control unit (store)
//   ctrl_regbankconfig  register-bank write enable from the control unit
//   ctrl_regsource      write-back source: 00 ALU, 01 LOAD, 10 PC
//   mem_ready           RAM access-complete strobe
//   ir_load             latch program memory output into the IR (FETCH)
//   pc_enable           program counter update strobe (WRITEBACK)
//   ram_wenable         gated RAM write enable (MEMORY, store)
//   ram_renable         RAM read strobe (MEMORY, load)
//   regbank_wenable     gated register-bank write enable (WRITEBACK)
//   state               current FSM state encoding (also the debug view)
//   busy                high in FETCH..WRITEBACK
//   instr_count         retired instruction count (wraps)
//   cycle_count         active cycle count (wraps)
// -----------------------------------------------------------------------------
module instruction_sequencer #(
  parameter int unsigned WAIT_LIMIT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic        halt_req,
  input  logic        ctrl_ramconfig,
  input  logic        ctrl_regbankconfig,
  input  logic [1:0]  ctrl_regsource,
  input  logic        mem_ready,
  output logic        ir_load,
  output logic        pc_enable,
  output logic        ram_wenable,
  output logic        ram_renable,
  output logic        regbank_wenable,
  output logic [2:0]  state,
  output logic        busy,
  output logic [31:0] instr_count,
  output logic [31:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALTED    = 3'd6,
    S_FAULT     = 3'd7
  } state_e;

  localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);
  localparam logic [1:0] SRC_LOAD = 2'b01;

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic        halt_pend_q, halt_pend_d;
  logic        store_q, store_d;
  logic [31:0] instr_count_q, instr_count_d;
  logic [31:0] cycle_count_q, cycle_count_d;
  logic        active;

  assign active = (state_q == S_FETCH)   || (state_q == S_DECODE)  ||
                  (state_q == S_EXECUTE) || (state_q == S_MEMORY)  ||
                  (state_q == S_WRITEBACK);

  // ---------------------------------------------------------------------------
  // State register and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      wait_q        <= 8'd0;
      halt_pend_q   <= 1'b0;
      store_q       <= 1'b0;
      instr_count_q <= 32'd0;
      cycle_count_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      halt_pend_q <= halt_pend_d;
      store_q     <= store_d;
      // The counters are written only when they change. This lets an
      // externally preloaded value stay in place until the next real update.
      if (state_q == S_WRITEBACK) instr_count_q <= instr_count_d;
      if (active)                 cycle_count_q <= cycle_count_d;
    end
  end

  assign instr_count_d = instr_count_q + 32'd1;
  assign cycle_count_d = cycle_count_q + 32'd1;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    halt_pend_d = halt_pend_q;
    store_d     = store_q;

    // A halt only counts while an instruction is in flight. It is held until
    // the instruction retires.
    if (halt_req && active) halt_pend_d = 1'b1;

    case (state_q)
      S_IDLE, S_HALTED: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH:   state_d = S_DECODE;
      S_DECODE:  state_d = S_EXECUTE;
      S_EXECUTE: begin
        if (ctrl_ramconfig || (ctrl_regsource == SRC_LOAD)) begin
          state_d = S_MEMORY;
          wait_d  = 8'd0;
          // When both a store and a load are indicated, the store wins.
          // The choice is captured here so the direction stays fixed for
          // the whole access.
          store_d = ctrl_ramconfig;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEMORY: begin
        // mem_ready is checked first. A ready strobe in the same cycle that
        // the limit is reached still completes the access.
        if (mem_ready) begin
          state_d = S_WRITEBACK;
        end else begin
          wait_d = wait_q + 8'd1;
          if (wait_d == LIMIT) state_d = S_FAULT;
        end
      end
      S_WRITEBACK: begin
        if (halt_pend_q || halt_req) begin
          state_d     = S_HALTED;
          halt_pend_d = 1'b0;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_FAULT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs. Most outputs decode only the state. The RAM direction comes from
  // the captured access type. regbank_wenable passes the control unit's
  // write enable through during WRITEBACK.
  // ---------------------------------------------------------------------------
  assign state           = state_q;
  assign busy            = active;
  assign ir_load         = (state_q == S_FETCH);
  assign pc_enable       = (state_q == S_WRITEBACK);
  assign ram_wenable     = (state_q == S_MEMORY) && store_q;
  assign ram_renable     = (state_q == S_MEMORY) && !store_q;
  assign regbank_wenable = (state_q == S_WRITEBACK) && ctrl_regbankconfig;
  assign instr_count     = instr_count_q;
  assign cycle_count     = cycle_count_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instruction_sequencer
//
// Directed bench for instruction_sequencer. Each test scenario is written in
// terms of instructions: a kind, a write-back enable, a MEMORY duration and
// where any halt request falls. The drivers turn each instruction into the
// sequence of stages it must go through. For every cycle they queue the
// outputs required in that cycle. A single negedge process compares the DUT
// against the head of that queue. Literal checks are added at key points to
// pin the expected values.
// -----------------------------------------------------------------------------
module tb_instruction_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic        halt_req = 1'b0;
  logic        ctrl_ramconfig = 1'b0;
  logic        ctrl_regbankconfig = 1'b0;
  logic [1:0]  ctrl_regsource = 2'b00;
  logic        mem_ready = 1'b0;
  logic        ir_load, pc_enable, ram_wenable, ram_renable, regbank_wenable;
  logic [2:0]  state;
  logic        busy;
  logic [31:0] instr_count, cycle_count;

  instruction_sequencer #(.WAIT_LIMIT(8)) dut (
    .clock              (clock),
    .reset              (reset),
    .run                (run),
    .halt_req           (halt_req),
    .ctrl_ramconfig     (ctrl_ramconfig),
    .ctrl_regbankconfig (ctrl_regbankconfig),
    .ctrl_regsource     (ctrl_regsource),
    .mem_ready          (mem_ready),
    .ir_load            (ir_load),
    .pc_enable          (pc_enable),
    .ram_wenable        (ram_wenable),
    .ram_renable        (ram_renable),
    .regbank_wenable    (regbank_wenable),
    .state              (state),
    .busy               (busy),
    .instr_count        (instr_count),
    .cycle_count        (cycle_count)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  always #5 clock = ~clock;

  // ---------------------------------------------------------------------------
  // Expected-value model
  // ---------------------------------------------------------------------------
  localparam int W = 73;
  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BOTH = 3, K_PC = 4;

  int          checks = 0;
  int          errors = 0;
  logic        check_en = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [31:0] m_instr = 32'd0;
  logic [31:0] m_cycle = 32'd0;
  int          cur_kind = K_ALU;
  logic        cur_rbc = 1'b0;

  // This function builds the output record that a cycle spent in stage st
  // must show. The record fields are: state, ir_load, pc_enable, ram_wenable,
  // ram_renable, regbank_wenable, busy, instr_count and cycle_count.
  function automatic logic [W-1:0] expect_rec(input int st, input int kind,
                                              input logic rbc,
                                              input logic [31:0] ic,
                                              input logic [31:0] cc);
    logic is_store, is_load, in_mem, in_wb;
    logic [2:0] s3;
    s3       = 3'(st);
    is_store = (kind == K_STORE) || (kind == K_BOTH);
    is_load  = (kind == K_LOAD);
    in_mem   = (st == 4);
    in_wb    = (st == 5);
    return {s3, (st == 1), in_wb, in_mem && is_store, in_mem && is_load,
            in_wb && rbc, (st >= 1 && st <= 5), ic, cc};
  endfunction

  function automatic string fmt(input logic [W-1:0] r);
    return $sformatf("st=%0d ir=%b pc=%b wen=%b ren=%b rbw=%b busy=%b ic=%h cc=%h",
                     r[72:70], r[69], r[68], r[67], r[66], r[65], r[64],
                     r[63:32], r[31:0]);
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard: one comparison per active cycle
  // ---------------------------------------------------------------------------
  always @(negedge clock) begin : compare
    logic [W-1:0] act, expv;
    if (check_en) begin
      act = {state, ir_load, pc_enable, ram_wenable, ram_renable,
             regbank_wenable, busy, instr_count, cycle_count};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL cycle_queue_empty t=%0t actual %s", $time, fmt(act));
      end else begin
        expv = exp_q.pop_front();
        if (act !== expv) begin
          errors++;
          $display("FAIL cycle t=%0t actual %s required %s", $time, fmt(act), fmt(expv));
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s t=%0t actual %h required %h", name, $time, act, expv);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (called at posedge+1; each do_cycle covers one clock cycle)
  // ---------------------------------------------------------------------------
  task automatic set_instr(input int kind, input logic rbc);
    cur_kind           = kind;
    cur_rbc            = rbc;
    ctrl_regbankconfig = rbc;
    ctrl_ramconfig     = (kind == K_STORE) || (kind == K_BOTH);
    case (kind)
      K_LOAD, K_BOTH: ctrl_regsource = 2'b01;
      K_PC:           ctrl_regsource = 2'b10;
      default:        ctrl_regsource = 2'b00;
    endcase
  endtask

  task automatic do_cycle(input int st, input logic run_v, input logic halt_v,
                          input logic rdy_v);
    run       = run_v;
    halt_req  = halt_v;
    mem_ready = rdy_v;
    exp_q.push_back(expect_rec(st, cur_kind, cur_rbc, m_instr, m_cycle));
    if (st >= 1 && st <= 5) m_cycle = m_cycle + 32'd1;
    if (st == 5)            m_instr = m_instr + 32'd1;
    @(posedge clock);
    #1;
  endtask

  // Runs one instruction, starting in the cycle in which the DUT is in FETCH.
  // nmem is the number of MEMORY cycles; mem_ready is high on the last one.
  task automatic run_instr(input int kind, input logic rbc, input int nmem,
                           input logic halt_dec, input logic halt_wb);
    set_instr(kind, rbc);
    do_cycle(1, 1'b0, 1'b0, 1'b0);
    do_cycle(2, 1'b0, halt_dec, 1'b0);
    do_cycle(3, 1'b0, 1'b0, 1'b0);
    if (kind == K_LOAD || kind == K_STORE || kind == K_BOTH)
      for (int i = 1; i <= nmem; i++) do_cycle(4, 1'b0, 1'b0, (i == nmem));
    do_cycle(5, 1'b0, halt_wb, 1'b0);
  endtask

  task automatic do_reset();
    check_en  = 1'b0;
    run       = 1'b0;
    halt_req  = 1'b0;
    mem_ready = 1'b0;
    reset     = 1'b1;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobes", 32'({ir_load, pc_enable, ram_wenable, ram_renable, regbank_wenable}), 32'd0);
    chk("rst_instr_count", instr_count, 32'd0);
    chk("rst_cycle_count", cycle_count, 32'd0);
    @(posedge clock);
    #1;
    reset   = 1'b0;
    m_instr = 32'd0;
    m_cycle = 32'd0;
    exp_q.delete();
    check_en = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog t=%0t simulation did not complete", $time);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  initial begin
    #1;
    do_reset();

    // Leaving reset must not start execution.
    for (int i = 0; i < 3; i++) do_cycle(0, 1'b0, 1'b0, 1'b0);
    do_cycle(0, 1'b1, 1'b0, 1'b0);

    // ALU instruction: 1,2,3,5 then back to FETCH.
    run_instr(K_ALU, 1'b1, 0, 1'b0, 1'b0);
    chk("alu_next_state", 32'(state), 32'd1);
    chk("alu_instr_count", instr_count, 32'd1);
    chk("alu_cycle_count", cycle_count, 32'd4);
    chk("model_alu_instr", m_instr, 32'd1);

    // Halt request in DECODE: the instruction completes, then HALTED.
    run_instr(K_ALU, 1'b0, 0, 1'b1, 1'b0);
    chk("halted_state", 32'(state), 32'd6);
    chk("halted_busy", 32'(busy), 32'd0);
    do_cycle(6, 1'b0, 1'b1, 1'b0);   // halt_req while HALTED is ignored
    do_cycle(6, 1'b0, 1'b0, 1'b0);
    do_cycle(6, 1'b1, 1'b0, 1'b0);
    run_instr(K_PC, 1'b1, 0, 1'b0, 1'b0);
    chk("resume_instr_count", instr_count, 32'd3);
    chk("resume_state", 32'(state), 32'd1);

    // Load with mem_ready on the third MEMORY cycle, from a clean start.
    do_reset();
    do_cycle(0, 1'b1, 1'b0, 1'b0);
    run_instr(K_LOAD, 1'b1, 3, 1'b0, 1'b0);
    chk("load_cycle_count", cycle_count, 32'd7);
    chk("model_load_cycles", m_cycle, 32'd7);
    chk("load_instr_count", instr_count, 32'd1);

    // Store, and the combination store+load, which is treated as a store.
    run_instr(K_STORE, 1'b0, 1, 1'b0, 1'b0);
    run_instr(K_BOTH, 1'b1, 2, 1'b0, 1'b0);

    // Halt request in the WRITEBACK cycle itself.
    run_instr(K_ALU, 1'b1, 0, 1'b0, 1'b1);
    chk("wb_halt_state", 32'(state), 32'd6);
    do_cycle(6, 1'b1, 1'b0, 1'b0);
    // Entering HALTED cleared the pending halt, so this one continues.
    run_instr(K_ALU, 1'b0, 0, 1'b0, 1'b0);
    chk("pending_cleared_state", 32'(state), 32'd1);

    // mem_ready arrives on the 8th MEMORY cycle, the same cycle as the
    // limit: WRITEBACK must win.
    run_instr(K_STORE, 1'b0, 8, 1'b0, 1'b0);
    chk("limit_ready_state", 32'(state), 32'd1);

    // A store that never completes: 8 MEMORY cycles, then FAULT, which
    // ignores run and halt_req.
    set_instr(K_STORE, 1'b1);
    do_cycle(1, 1'b0, 1'b0, 1'b0);
    do_cycle(2, 1'b0, 1'b0, 1'b0);
    do_cycle(3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) do_cycle(4, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) do_cycle(7, 1'b1, 1'b1, 1'b0);
    chk("fault_state", 32'(state), 32'd7);

    // Reset from FAULT returns to IDLE with cleared counters.
    do_reset();

    // Reset in the middle of a store's MEMORY stage.
    do_cycle(0, 1'b1, 1'b0, 1'b0);
    set_instr(K_STORE, 1'b1);
    do_cycle(1, 1'b0, 1'b0, 1'b0);
    do_cycle(2, 1'b0, 1'b0, 1'b0);
    do_cycle(3, 1'b0, 1'b0, 1'b0);
    do_cycle(4, 1'b0, 1'b0, 1'b0);
    check_en = 1'b0;
    chk("mid_store_wen", 32'(ram_wenable), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_wen", 32'(ram_wenable), 32'd0);
    chk("async_rst_state", 32'(state), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_pc_enable", 32'(pc_enable), 32'd0);
      chk("post_rst_regbank", 32'(regbank_wenable), 32'd0);
      @(negedge clock);
      chk("post_rst_state", 32'(state), 32'd0);
      @(posedge clock);
      #1;
    end
    m_instr  = 32'd0;
    m_cycle  = 32'd0;
    check_en = 1'b1;

    // instr_count wraps from 0xFFFFFFFF to 0.
    do_cycle(0, 1'b0, 1'b0, 1'b0);
    force dut.instr_count_q = 32'hFFFF_FFFF;
    m_instr = 32'hFFFF_FFFF;
    do_cycle(0, 1'b0, 1'b0, 1'b0);
    release dut.instr_count_q;
    do_cycle(0, 1'b0, 1'b0, 1'b0);
    do_cycle(0, 1'b1, 1'b0, 1'b0);
    run_instr(K_ALU, 1'b1, 0, 1'b0, 1'b0);
    chk("wrap_instr_count", instr_count, 32'd0);
    chk("wrap_cycle_count", cycle_count, 32'd4);
    chk("wrap_state", 32'(state), 32'd1);
    chk("model_wrap_instr", m_instr, 32'd0);

    check_en = 1'b0;
    chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_sequencer.md
INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 Parameter WAIT_LIMIT, default 8, maximum MEMORY-state cycles spent waiting for mem_ready before FAULT (range 1..255).
REQ-002 clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high; forces the reset state immediately.
REQ-004 run  input  1  start/resume request, sampled in IDLE and HALTED only.
REQ-005 halt_req  input  1  single-cycle halt request, honoured at the next instruction boundary.
REQ-006 ctrl_ramconfig  input  1  control_unit RAM write enable (store instruction).
REQ-007 ctrl_regbankconfig  input  1  control_unit register-bank write enable.
REQ-008 ctrl_regsource  input  2  control_unit write-back source: 00 ALU, 01 LOAD, 10 PC.
REQ-009 mem_ready  input  1  RAM access-complete strobe.
REQ-010 ir_load  output  1  latch the program_memory output into the instruction register.
REQ-011 pc_enable  output  1  program_counter update strobe.
REQ-012 ram_wenable  output  1  gated RAM write enable.
REQ-013 ram_renable  output  1  RAM read strobe.
REQ-014 regbank_wenable  output  1  gated register-bank write enable.
REQ-015 state  output  3  current state encoding.
REQ-016 busy  output  1  high in states 1-5.
REQ-017 instr_count  output  32  count of retired instructions.
REQ-018 cycle_count  output  32  count of active cycles.

Function
REQ-019 States SHALL be: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALTED=6, FAULT=7.
REQ-020 IDLE/HALTED SHALL go to FETCH when run=1 and stay otherwise.
REQ-021 FETCH SHALL assert ir_load for exactly one cycle, then go to DECODE.
REQ-022 DECODE SHALL last one cycle, then go to EXECUTE.
REQ-023 EXECUTE SHALL last one cycle, then go to MEMORY if ctrl_ramconfig=1 or ctrl_regsource=01, else to WRITEBACK.
REQ-024 If ctrl_ramconfig=1 and ctrl_regsource=01 together, the access SHALL be treated as a store.
REQ-025 MEMORY: ram_wenable (store) or ram_renable (load) SHALL be high every MEMORY cycle and low in all other states.
REQ-026 MEMORY SHALL go to WRITEBACK in the cycle after mem_ready is sampled high.
REQ-027 A wait counter SHALL clear on MEMORY entry and increment each MEMORY cycle with mem_ready=0.
REQ-028 When the wait counter reaches WAIT_LIMIT, the next state SHALL be FAULT.
REQ-029 If mem_ready=1 in the same cycle the limit is reached, WRITEBACK SHALL win.
REQ-030 WRITEBACK SHALL last one cycle with pc_enable=1 and regbank_wenable=ctrl_regbankconfig; regbank_wenable SHALL be 0 in every other state.
REQ-031 WRITEBACK SHALL increment instr_count by 1, wrapping from 0xFFFFFFFF to 0.
REQ-032 A halt_req pulse in any of states 1-5 SHALL set a sticky halt_pending; halt_req in IDLE, HALTED or FAULT SHALL be ignored.
REQ-033 WRITEBACK SHALL go to HALTED if halt_pending (or halt_req in that cycle) is set, else to FETCH; entering HALTED SHALL clear halt_pending.
REQ-034 FAULT SHALL hold all strobes low and be left only by reset; run is ignored in FAULT.
REQ-035 cycle_count SHALL increment in states 1-5 only and wrap at 2^32.
REQ-036 Outputs other than regbank_wenable and the ram_wenable/ram_renable select SHALL be pure functions of state (Moore).

Reset
REQ-037 Reset SHALL force state=IDLE, halt_pending=0, wait counter=0, instr_count=0 and cycle_count=0, with all strobes and busy at 0, within the same cycle regardless of the current state.
REQ-038 Deassertion of reset SHALL NOT start execution; run is required.
REQ-039 Reset asserted in MEMORY during a store SHALL drop ram_wenable immediately, and no pc_enable or regbank_wenable SHALL follow.

Verification
REQ-040 ALU instruction (ramconfig=0, regsource=00, regbankconfig=1), run pulse -> states 1,2,3,5,1; pc_enable and regbank_wenable high only in cycle 4; instr_count=1.
REQ-041 Load (regsource=01), mem_ready high on the 3rd MEMORY cycle -> ram_renable high for 3 cycles, WRITEBACK follows, cycle_count=7 at the next FETCH.
REQ-042 Store, WAIT_LIMIT=8, mem_ready held 0 -> FAULT after 8 MEMORY cycles; run ignored; reset returns to IDLE with all counters 0.
REQ-043 halt_req pulsed in DECODE -> the instruction completes, state=HALTED with busy=0; run -> FETCH; instr_count continues from 1.
REQ-044 Reset asserted mid-MEMORY store -> ram_wenable=0 before the next edge, state=0, no pc_enable is observed.
REQ-045 instr_count preloaded via force to 0xFFFFFFFF plus one instruction -> instr_count=0, no other side effects.
